// File: rtl/datapath.sv
// Single-bus 32-bit datapath slice: PC, IR, MAR, MDR, Y, 64-bit Z, R4 and R6
// share one internal bus. All strobes come from an external control unit.
module datapath (
  input  logic        Clock,
  input  logic        Clear_n,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R6out,
  input  logic        R4out,
  input  logic        PCin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        Zin,
  input  logic        R6in,
  input  logic        R4in,
  input  logic        IncPC,
  input  logic        ROR,
  input  logic        Read,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut,
  output logic [31:0] PC_q,
  output logic [31:0] IR_q,
  output logic [31:0] MAR_q,
  output logic [31:0] MDR_q,
  output logic [31:0] Y_q,
  output logic [31:0] R4_q,
  output logic [31:0] R6_q,
  output logic [31:0] Zlow_q,
  output logic [31:0] Zhigh_q
);

  logic [31:0] mdr_d;
  logic [31:0] zlow_d;
  logic [31:0] zhigh_d;
  logic [63:0] y_dbl;
  logic [4:0]  shamt;

  // Bus priority mux; registers drive their old value, so load+drive is loop-free.
  always_comb begin
    BusMuxOut = '0;
    if (MDRout) begin
      BusMuxOut = MDR_q;
    end else if (Zlowout) begin
      BusMuxOut = Zlow_q;
    end else if (PCout) begin
      BusMuxOut = PC_q;
    end else if (R6out) begin
      BusMuxOut = R6_q;
    end else if (R4out) begin
      BusMuxOut = R4_q;
    end
  end

  // MDR input select: memory data on a read, bus otherwise.
  always_comb begin
    mdr_d = Read ? Mdatain : BusMuxOut;
  end

  // ALU: increment wins over rotate; rotate uses only the low 5 bus bits.
  always_comb begin
    shamt   = BusMuxOut[4:0];
    y_dbl   = {Y_q, Y_q} >> shamt;
    zhigh_d = '0;
    zlow_d  = BusMuxOut;
    if (IncPC) begin
      zlow_d = BusMuxOut + 32'd1;
    end else if (ROR) begin
      zlow_d = y_dbl[31:0];
    end
  end

  // Register file: each register loads on its in-strobe, all cleared asynchronously.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      PC_q    <= '0;
      IR_q    <= '0;
      MAR_q   <= '0;
      MDR_q   <= '0;
      Y_q     <= '0;
      R4_q    <= '0;
      R6_q    <= '0;
      Zlow_q  <= '0;
      Zhigh_q <= '0;
    end else begin
      if (PCin)  PC_q  <= BusMuxOut;
      if (IRin)  IR_q  <= BusMuxOut;
      if (MARin) MAR_q <= BusMuxOut;
      if (MDRin) MDR_q <= mdr_d;
      if (Yin)   Y_q   <= BusMuxOut;
      if (R4in)  R4_q  <= BusMuxOut;
      if (R6in)  R6_q  <= BusMuxOut;
      if (Zin) begin
        Zlow_q  <= zlow_d;
        Zhigh_q <= zhigh_d;
      end
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus pushes expected values, monitor compares.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear_n;
  logic        PCout, Zlowout, MDRout, R6out, R4out;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, R6in, R4in;
  logic        IncPC, ROR, Read;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, PC_q, IR_q, MAR_q, MDR_q, Y_q, R4_q, R6_q, Zlow_q, Zhigh_q;

  localparam int SBus = 0, SPc = 1, SIr = 2, SMar = 3, SMdr = 4, SY = 5, SR4 = 6,
                 SR6 = 7, SZlo = 8, SZhi = 9;

  typedef struct {
    int          id;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   n_pass = 0;
  int   n_total = 0;
  bit   done = 1'b0;

  datapath dut (
    .Clock(Clock), .Clear_n(Clear_n),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R6out(R6out), .R4out(R4out),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .R6in(R6in), .R4in(R4in), .IncPC(IncPC), .ROR(ROR), .Read(Read), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut), .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q),
    .Y_q(Y_q), .R4_q(R4_q), .R6_q(R6_q), .Zlow_q(Zlow_q), .Zhigh_q(Zhigh_q)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] get_sig(input int id);
    case (id)
      SBus:    return BusMuxOut;
      SPc:     return PC_q;
      SIr:     return IR_q;
      SMar:    return MAR_q;
      SMdr:    return MDR_q;
      SY:      return Y_q;
      SR4:     return R4_q;
      SR6:     return R6_q;
      SZlo:    return Zlow_q;
      default: return Zhigh_q;
    endcase
  endfunction

  // Monitor: on each observation point drain the scoreboard.
  initial begin
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e   = sb.pop_front();
        act = get_sig(e.id);
        n_total++;
        if (act === e.val) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.nm, act, e.val);
      end
    end
  end

  // Watchdog: the sequence must complete within a bounded time.
  initial begin
    #20000;
    if (!done) begin
      n_total++;
      $display("FAIL timeout: sequence did not complete");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end
  end

  task automatic check_eq(input logic [31:0] act, input logic [31:0] exp, input string nm);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input int id, input logic [31:0] v, input string nm);
    exp_t e;
    e.id = id; e.val = v; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic observe();
    -> chk_ev;
    #1;
  endtask

  task automatic clr_strobes();
    {PCout, Zlowout, MDRout, R6out, R4out} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zin, R6in, R4in} = '0;
    {IncPC, ROR, Read} = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    clr_strobes();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  task automatic pulse_clear();
    Clear_n = 1'b0;
    #1;
    check_eq(PC_q, 0, "clr_pc");     check_eq(IR_q, 0, "clr_ir");
    check_eq(MAR_q, 0, "clr_mar");   check_eq(MDR_q, 0, "clr_mdr");
    check_eq(Y_q, 0, "clr_y");       check_eq(R4_q, 0, "clr_r4");
    check_eq(R6_q, 0, "clr_r6");     check_eq(Zlow_q, 0, "clr_zlo");
    check_eq(Zhigh_q, 0, "clr_zhi"); check_eq(BusMuxOut, 0, "clr_bus");
    Clear_n = 1'b1;
  endtask

  initial begin
    clr_strobes();
    Mdatain = '0;
    Clear_n = 1'b0;
    #2 Clear_n = 1'b1;

    // Reset: R6 = all ones, then asynchronous clear between edges
    load_mdr(32'hFFFF_FFFF);
    MDRout = 1; R6in = 1; tick();
    push(SR6, 32'hFFFF_FFFF, "r6_ones"); observe();
    pulse_clear();

    // Fetch from reset
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
    push(SMar, 32'h0, "fetch_mar"); push(SZlo, 32'h1, "fetch_zlo");
    push(SZhi, 32'h0, "fetch_zhi"); observe();
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h2891_8000; tick();
    push(SPc, 32'h1, "fetch_pc"); push(SMdr, 32'h2891_8000, "fetch_mdr"); observe();
    MDRout = 1; IRin = 1; tick();
    push(SIr, 32'h2891_8000, "fetch_ir"); observe();

    // Preloads
    load_mdr(32'h12);
    MDRout = 1; R6in = 1; tick();
    push(SR6, 32'h12, "pre_r6"); observe();
    load_mdr(32'h14);
    MDRout = 1; R4in = 1; tick();
    push(SR4, 32'h14, "pre_r4"); observe();

    // ROR execute
    R6out = 1; Yin = 1; tick();
    push(SY, 32'h12, "ror_y"); observe();
    R4out = 1; ROR = 1; Zin = 1; tick();
    push(SZlo, 32'h0001_2000, "ror_zlo"); push(SZhi, 32'h0, "ror_zhi"); observe();
    Zlowout = 1; R6in = 1; tick();
    push(SR6, 32'h0001_2000, "ror_r6"); observe();

    // ROR edge cases, Y = 0x80000001
    load_mdr(32'h8000_0001);
    MDRout = 1; Yin = 1; tick();
    ROR = 1; Zin = 1; tick();
    push(SZlo, 32'h8000_0001, "ror_amt0"); observe();
    load_mdr(32'h1);
    MDRout = 1; ROR = 1; Zin = 1; tick();
    push(SZlo, 32'hC000_0000, "ror_amt1"); observe();
    load_mdr(32'd31);
    MDRout = 1; ROR = 1; Zin = 1; tick();
    push(SZlo, 32'h0000_0003, "ror_amt31"); observe();
    load_mdr(32'h21);
    MDRout = 1; ROR = 1; Zin = 1; tick();
    push(SZlo, 32'hC000_0000, "ror_amt33"); observe();

    // Bus priority: MDR (0x21) over PC (1), Zlow over PC
    MDRout = 1; PCout = 1; #1;
    push(SBus, 32'h21, "prio_mdr_pc"); observe();
    clr_strobes();
    Zlowout = 1; PCout = 1; R4out = 1; #1;
    push(SBus, 32'hC000_0000, "prio_z_pc"); observe();
    clr_strobes();
    R6out = 1; R4out = 1; #1;
    push(SBus, 32'h0001_2000, "prio_r6_r4"); observe();
    clr_strobes();

    // PC wrap
    load_mdr(32'hFFFF_FFFF);
    MDRout = 1; PCin = 1; tick();
    PCout = 1; IncPC = 1; Zin = 1; tick();
    push(SZlo, 32'h0, "wrap_zlo"); push(SZhi, 32'h0, "wrap_zhi"); observe();

    // IncPC beats ROR
    load_mdr(32'h21);
    MDRout = 1; IncPC = 1; ROR = 1; Zin = 1; tick();
    push(SZlo, 32'h22, "inc_over_ror"); push(SR4, 32'h14, "r4_hold"); observe();

    // Mid-sequence clear discards Z
    pulse_clear();

    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Single-bus 32-bit CPU datapath slice: PC, IR, MAR, MDR, Y, 64-bit Z, and general registers R4 and R6 share one internal bus. An external control unit or testbench drives every register-enable, bus-drive and ALU-operation strobe. The ALU supports PC increment and rotate-right (ROR). Memory-read data enters through MDR.

## Interface
- Parameters: none (data width fixed at 32).
- Clock  in  1  rising-edge clock for all registers
- Clear_n  in  1  asynchronous active-low reset; clears every register
- PCout, Zlowout, MDRout, R6out, R4out  in  1 each  bus-drive strobes
- PCin, MARin, MDRin, IRin, Yin, Zin, R6in, R4in  in  1 each  register load enables
- IncPC  in  1  ALU op: bus + 1
- ROR  in  1  ALU op: rotate Y right
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus
- Mdatain  in  32  memory read data
- BusMuxOut  out  32  current bus value (observation)
- PC_q, IR_q, MAR_q, MDR_q, Y_q, R4_q, R6_q  out  32 each  register contents (observation)
- Zlow_q, Zhigh_q  out  32 each  Z register halves (observation)

## Operation
- Bus is a combinational priority mux: MDRout > Zlowout > PCout > R6out > R4out.
- If no out-strobe is asserted, BusMuxOut = 0.
- A register loads on the rising Clock edge when its in-strobe is high; otherwise it holds.
- PC, IR, MAR, Y, R4, R6 load BusMuxOut.
- MDR loads Mdatain when Read = 1, otherwise BusMuxOut.
- ALU result is 64 bits {Zhigh, Zlow}, combinational:
  - IncPC = 1: Zlow = BusMuxOut + 1 (mod 2^32), Zhigh = 0. IncPC has priority over ROR.
  - ROR = 1: Zlow = Y rotated right by BusMuxOut[4:0]; Zhigh = 0. Shift amount 0 gives Y unchanged. Bits [31:5] of the shift amount are ignored.
  - Neither: Zlow = BusMuxOut, Zhigh = 0.
- Z loads the ALU result when Zin = 1.
- Only Zlow can drive the bus.
- Simultaneous load and drive of the same register: the bus carries the old value and the register captures it, so there is no combinational loop.

## Timing
- Clear_n low: every register goes to 0 immediately, independent of Clock. Outputs read 0; BusMuxOut is 0 unless Mdatain reaches it via MDR, which is itself 0.
- Clear_n deassertion is asynchronous; the first load occurs at the next rising edge.
- Clear_n low mid-sequence discards all state, including an in-progress Z result.
- Every register has 1-cycle latency: strobes and data must be stable before the rising edge, and the new value is visible after it.
- ALU and bus are purely combinational, so drive, compute and capture into Z happen in the same cycle.
- There is no handshake. Read is a mux select only; Mdatain must be valid in the cycle where Read and MDRin are high.
- Strobes may toggle mid-cycle; only values at the rising edge matter.

## Test plan
- Reset: load R6 = 0xFFFFFFFF, then pulse Clear_n low between edges -> all *_q outputs read 0 immediately, with no Clock edge needed.
- Register preload: Mdatain = 0x12, Read + MDRin for one edge, then MDRout + R6in -> R6_q = 0x00000012. Repeat with Mdatain = 0x14 into R4 -> R4_q = 0x00000014.
- Fetch, from reset:
  - PCout, MARin, IncPC, Zin -> MAR_q = 0, Zlow_q = 1.
  - Zlowout, PCin, Read, MDRin, Mdatain = 0x28918000 -> PC_q = 1, MDR_q = 0x28918000.
  - MDRout, IRin -> IR_q = 0x28918000.
- ROR execute, after the preloads:
  - R6out, Yin -> Y_q = 0x12.
  - R4out, ROR, Zin -> Zlow_q = 0x00012000, Zhigh_q = 0.
  - Zlowout, R6in -> R6_q = 0x00012000.
- ROR edge cases, with Y = 0x80000001:
  - Amount 0 (no out-strobe) -> Zlow = 0x80000001.
  - Amount 1 -> 0xC0000000.
  - Amount 31 -> 0x00000003.
  - Bus = 0x00000021 -> uses 1 -> 0xC0000000.
- Bus priority and wrap:
  - MDRout and PCout both high -> bus = MDR.
  - PC = 0xFFFFFFFF with PCout, IncPC, Zin -> Zlow_q = 0, Zhigh_q = 0.
  - IncPC and ROR both high -> increment result.
